// File: rtl/alu_seq.sv
// alu_seq: handshaked, multi-cycle 3-bit ALU.
// One request is accepted on the in_valid/in_ready port. Its result is returned
// on the out_valid/out_ready port. add/sub/and/or/xor and divide-by-zero finish
// in one cycle. mul (shift-add) and div/mod (restoring, MSB first) iterate for
// DATA_WIDTH cycles.
module alu_seq #(
  parameter int DATA_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  sel,
  input  logic [DATA_WIDTH-1:0]       in0,
  input  logic [DATA_WIDTH-1:0]       in1,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [2*DATA_WIDTH:0] out
);

  localparam int RW = 2*DATA_WIDTH + 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                state;
  logic [2:0]            op_sel;
  logic [CW-1:0]         count;
  logic [RW-1:0]         mcand;   // A shifted left once per MUL step
  logic [DATA_WIDTH-1:0] mplier;  // B shifted right once per MUL step
  logic [RW-1:0]         acc;
  logic [DATA_WIDTH-1:0] dvd;     // dividend, MSB consumed first
  logic [DATA_WIDTH-1:0] dvs;
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] quo;

  logic [RW-1:0]         ext_a, ext_b, fast_res;
  logic [RW-1:0]         acc_nxt;
  logic [DATA_WIDTH:0]   trial, diff;
  logic                  ge;
  logic [DATA_WIDTH-1:0] rem_nxt, quo_nxt;

  // Handshake flags are pure state decodes: no input-to-output path.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign ext_a = {{(RW-DATA_WIDTH){1'b0}}, in0};
  assign ext_b = {{(RW-DATA_WIDTH){1'b0}}, in1};

  // Single-cycle results. These are formed from the request at the accept
  // edge, which is the same value the captured operands would give.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    fast_res = '0;
    case (sel)
      3'd0:    fast_res = ext_a + ext_b;
      3'd1:    fast_res = ext_a - ext_b;
      3'd4:    fast_res = ext_a & ext_b;
      3'd5:    fast_res = ext_a | ext_b;
      3'd6:    fast_res = ext_a ^ ext_b;
      default: fast_res = '0;
    endcase
  end

  // One shift-add step and one restoring-division step.
  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    trial   = {rem, dvd[DATA_WIDTH-1]};
    diff    = trial - {1'b0, dvs};
    ge      = (trial >= {1'b0, dvs});
    rem_nxt = ge ? diff[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
    quo_nxt = quo << 1;
    quo_nxt[0] = ge;
  end

  // Control FSM and datapath registers. The last iteration writes out directly,
  // so DONE is reached DATA_WIDTH edges after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_sel <= '0;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      quo    <= '0;
      out    <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_sel <= sel;
            count  <= '0;
            case (sel)
              3'd2: begin
                mcand  <= ext_a;
                mplier <= in1;
                acc    <= '0;
                state  <= MUL;
              end
              3'd3, 3'd7: begin
                if (in1 == '0) begin
                  out   <= '0;
                  state <= DONE;
                end else begin
                  dvd   <= in0;
                  dvs   <= in1;
                  rem   <= '0;
                  quo   <= '0;
                  state <= DIV;
                end
              end
              default: begin
                out   <= fast_res;
                state <= DONE;
              end
            endcase
          end
        end
        MUL: begin
          if (count == LAST) begin
            out   <= acc_nxt;
            state <= DONE;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
          end
        end
        DIV: begin
          if (count == LAST) begin
            out   <= (op_sel == 3'd3) ? {{(RW-DATA_WIDTH){1'b0}}, quo_nxt}
                                      : {{(RW-DATA_WIDTH){1'b0}}, rem_nxt};
            state <= DONE;
          end else begin
            rem   <= rem_nxt;
            quo   <= quo_nxt;
            dvd   <= dvd << 1;
            count <= count + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and exhaustive bench for alu_seq (DATA_WIDTH=3).
module tb_alu_seq;

  localparam int W = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         sel;
  logic [W-1:0]       in0, in1;
  logic               out_valid;
  logic               out_ready;
  logic signed [2*W:0] out;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .in0       (in0),
    .in1       (in1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; sample and drive 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic on plain integers.
  function automatic int ref_model(input int s, input int a, input int b);
    case (s)
      0: return a + b;
      1: return a - b;
      2: return a * b;
      3: return (b == 0) ? 0 : a / b;
      4: return a & b;
      5: return a | b;
      6: return a ^ b;
      default: return (b == 0) ? 0 : a % b;
    endcase
  endfunction

  // Called just after the accept edge; counts cycles until out_valid,
  // checking in_ready stays low meanwhile. lat=1 means valid right after accept.
  task automatic wait_valid(input string tag, output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      check({tag, "_busy_ready"}, in_ready, 0);
      tick();
      lat++;
    end
  endtask

  // One directed transaction with out_ready held high.
  task automatic do_op(input string tag, input logic [2:0] s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int exp_out, input int exp_lat);
    int lat;
    out_ready = 1'b1;
    check({tag, "_ready_before"}, in_ready, 1);
    sel = s; in0 = a; in1 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in0 = ~a; in1 = ~b; sel = ~s;   // later input changes must not matter
    wait_valid(tag, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_out"}, out, exp_out);
    tick();
    check({tag, "_ready_after"}, in_ready, 1);
    check({tag, "_valid_after"}, out_valid, 0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sel = '0; in0 = '0; in1 = '0;

    // Reset state
    #2;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_out", out, 0);
    #10 rst_n = 1'b1;
    tick();
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);

    // Single-cycle ops
    do_op("add", 3'd0, 3'd5, 3'd7, 12, 1);
    do_op("sub", 3'd1, 3'd2, 3'd6, -4, 1);
    do_op("and", 3'd4, 3'd6, 3'd3, 2, 1);
    do_op("or",  3'd5, 3'd6, 3'd3, 7, 1);
    do_op("xor", 3'd6, 3'd6, 3'd3, 5, 1);
    do_op("sub_min", 3'd1, 3'd0, 3'd7, -7, 1);

    // Multiply
    do_op("mul77", 3'd2, 3'd7, 3'd7, 49, 4);
    do_op("mul50", 3'd2, 3'd5, 3'd0, 0, 4);

    // Divide / modulo
    do_op("div72", 3'd3, 3'd7, 3'd2, 3, 4);
    do_op("mod72", 3'd7, 3'd7, 3'd2, 1, 4);
    do_op("div50", 3'd3, 3'd5, 3'd0, 0, 1);
    do_op("mod50", 3'd7, 3'd5, 3'd0, 0, 1);
    do_op("xor_set", 3'd6, 3'd6, 3'd3, 5, 1);   // leave out nonzero

    // Reset in the middle of a divide
    sel = 3'd3; in0 = 3'd7; in1 = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_out", out, 0);
    check("midrst_ready", in_ready, 1);
    #2 rst_n = 1'b1;
    tick();
    check("midrst_no_valid", out_valid, 0);
    do_op("add11", 3'd0, 3'd1, 3'd1, 2, 1);

    // Backpressure
    out_ready = 1'b0;
    sel = 3'd2; in0 = 3'd3; in1 = 3'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("bp", lat);
    check("bp_lat", lat, 4);
    check("bp_out", out, 6);
    for (int i = 0; i < 5; i++) begin
      sel = 3'd0; in0 = 3'd1; in1 = 3'd1; in_valid = 1'b1;
      tick();
      check("bp_hold_out", out, 6);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_ready_after", in_ready, 1);
    check("bp_valid_after", out_valid, 0);
    check("bp_out_held", out, 6);
    tick();
    check("bp_dropped", out_valid, 0);
    check("bp_out_still", out, 6);

    // Exhaustive with random stalls and idle gaps
    for (int i = 0; i < 512; i++) begin
      logic [2:0] s, a, b;
      logic signed [31:0] got;
      bit done;
      s = i[8:6]; a = i[5:3]; b = i[2:0];
      repeat ($urandom_range(0, 2)) tick();
      check("exh_ready", in_ready, 1);
      sel = s; in0 = a; in1 = b; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in0 = $urandom_range(0, 7); in1 = $urandom_range(0, 7);
      got = 'x;
      done = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (out_valid && out_ready) begin
          got = out;
          done = 1'b1;
        end
        tick();
      end
      check($sformatf("exh_s%0d_a%0d_b%0d", s, a, b), got, ref_model(s, a, b));
      check("exh_no_dup", out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
